// File: rtl/booth_mul_seq_pkg.sv
// Shared ALU definitions for the sequential Booth multiplier: FSM encoding,
// Booth step select codes and the default operand width.
package booth_mul_seq_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_1}.
    function automatic booth_op_t booth_select(input logic q0, input logic q_1);
        booth_op_t op;
        case ({q0, q_1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mul_seq_neg.sv
// Two's-complement negation, used to precompute -M when an operation is loaded.
module booth_mul_seq_neg #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = ~x + WIDTH'(1);

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one recoding step per cycle, WIDTH steps,
// registered 2*WIDTH-bit signed product with a start/ready/busy/done handshake.
module booth_mul_seq
    import booth_mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t               state_reg;
    state_t               state_next;
    logic [WIDTH:0]       m_reg;
    logic [WIDTH:0]       neg_m_reg;
    logic [WIDTH:0]       acc_reg;
    logic [WIDTH-1:0]     q_reg;
    logic                 q1_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2*WIDTH-1:0]   product_reg;

    logic [WIDTH:0]       a_ext;
    logic [WIDTH:0]       neg_a_ext;
    logic [WIDTH:0]       sum_next;
    logic [2*WIDTH+1:0]   shift_next;
    logic                 last_step;
    booth_op_t            op;

    // The extra bit keeps -M representable when a is the most negative value.
    assign a_ext = {a[WIDTH-1], a};

    booth_mul_seq_neg #(
        .WIDTH(WIDTH + 1)
    ) u_neg (
        .x(a_ext),
        .y(neg_a_ext)
    );

    assign last_step = (cnt_reg == CNT_W'(1));

    always_comb begin
        op       = booth_select(q_reg[0], q1_reg);
        sum_next = acc_reg;
        case (op)
            BOOTH_ADD: sum_next = acc_reg + m_reg;
            BOOTH_SUB: sum_next = acc_reg + neg_m_reg;
            default:   sum_next = acc_reg;
        endcase
        // Arithmetic right shift of {ACC', Q, q_1}; the old q_1 falls off the end.
        shift_next = {sum_next[WIDTH], sum_next, q_reg};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg       <= '0;
            neg_m_reg   <= '0;
            acc_reg     <= '0;
            q_reg       <= '0;
            q1_reg      <= 1'b0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        m_reg     <= a_ext;
                        neg_m_reg <= neg_a_ext;
                        acc_reg   <= '0;
                        q_reg     <= b;
                        q1_reg    <= 1'b0;
                        cnt_reg   <= CNT_W'(WIDTH);
                    end
                end
                CALC: begin
                    acc_reg <= shift_next[2*WIDTH+1:WIDTH+1];
                    q_reg   <= shift_next[WIDTH:1];
                    q1_reg  <= shift_next[0];
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (last_step) begin
                        product_reg <= shift_next[2*WIDTH:1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready   = (state_reg == IDLE);
    assign busy    = (state_reg == CALC);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq at WIDTH=3 with hand-computed products.
`timescale 1ns/1ps
module tb_booth_mul_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] a;
    logic [2:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [5:0] product;

    int total = 0;
    int bad   = 0;

    booth_mul_seq #(.WIDTH(3)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one multiply and wait (bounded) for done; ok=0 if it never came.
    task automatic run_op(input logic [2:0] av, input logic [2:0] bv,
                          output logic [5:0] p, output bit ok);
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        p  = 6'bx;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                p  = product;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 3'd0; b = 3'd0;
        tick(); tick();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (product !== 6'd0) begin bad++; $display("FAIL reset_product got=%b want=000000", product); end
        rst = 1'b0;
        tick();
        $display("test_reset: ready=%b busy=%b done=%b product=%b", ready, busy, done, product);
    endtask

    task automatic test_basic();
        a = 3'd3; b = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL basic_busy cycle=%0d got busy=%b done=%b want busy=1 done=0", i, busy, done);
            end
            if (i < 2) tick();
        end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done_latency got=%b want=1", done); end
        total++; if (product !== 6'b001001) begin bad++; $display("FAIL basic_product got=%b want=001001", product); end
        tick();
        total++; if (done !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL basic_after got done=%b ready=%b want done=0 ready=1", done, ready);
        end
        $display("test_basic: 3*3 product=%b", product);
    endtask

    task automatic test_extremes();
        logic [5:0] p;
        bit ok;
        run_op(3'b100, 3'b100, p, ok);
        total++; if (!ok || p !== 6'b010000) begin bad++; $display("FAIL ext_m4_m4 got=%b ok=%0d want=010000", p, ok); end
        $display("test_extremes: -4*-4 product=%b", p);
        run_op(3'b100, 3'b011, p, ok);
        total++; if (!ok || p !== 6'b110100) begin bad++; $display("FAIL ext_m4_3 got=%b ok=%0d want=110100", p, ok); end
        $display("test_extremes: -4*3 product=%b", p);
    endtask

    task automatic test_exhaustive();
        logic [5:0] p;
        logic [5:0] want;
        bit ok;
        int prod;
        for (int ia = -4; ia < 4; ia++) begin
            for (int ib = -4; ib < 4; ib++) begin
                prod = ia * ib;
                want = prod[5:0];
                run_op(ia[2:0], ib[2:0], p, ok);
                total++;
                if (!ok || p !== want) begin
                    bad++; $display("FAIL exh a=%0d b=%0d got=%b ok=%0d want=%b", ia, ib, p, ok, want);
                end
                $display("test_exhaustive: a=%0d b=%0d product=%b", ia, ib, p);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        a = 3'd2; b = 3'd3; start = 1'b1;
        tick();
        a = 3'd1; b = 3'd1;
        // start stays high through all CALC cycles and the DONE cycle
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        total++; if (ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL ignore_state got ready=%b busy=%b want ready=1 busy=0", ready, busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dones++;
        end
        total++; if (dones != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        total++; if (product !== 6'b000110) begin bad++; $display("FAIL ignore_product got=%b want=000110", product); end
        $display("test_ignore_start: dones=%0d product=%b", dones, product);
    endtask

    task automatic test_reset_abort();
        logic [5:0] p;
        bit ok;
        a = 3'd3; b = 3'b110; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_flags got ready=%b busy=%b done=%b want 1/0/0", ready, busy, done);
        end
        total++; if (product !== 6'd0) begin bad++; $display("FAIL abort_product got=%b want=000000", product); end
        run_op(3'd1, 3'b111, p, ok);
        total++; if (!ok || p !== 6'b111111) begin bad++; $display("FAIL abort_next got=%b ok=%0d want=111111", p, ok); end
        $display("test_reset_abort: following 1*-1 product=%b", p);
    endtask

    task automatic test_idle_hold();
        logic [5:0] p;
        bit ok;
        run_op(3'd3, 3'd3, p, ok);
        total++; if (!ok || p !== 6'b001001) begin bad++; $display("FAIL hold_setup got=%b ok=%0d want=001001", p, ok); end
        for (int i = 0; i < 10; i++) begin
            a = ~a; b = b + 3'd1;
            tick();
            total++;
            if (product !== 6'b001001 || done !== 1'b0) begin
                bad++; $display("FAIL hold cycle=%0d got product=%b done=%b want 001001/0", i, product, done);
            end
        end
        $display("test_idle_hold: product=%b", product);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_exhaustive();
        test_ignore_start();
        test_reset_abort();
        test_idle_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
